// File: rtl/hazard_ctrl_param.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_param
//
// Hazard, forwarding and stall controller for the MIPS pipeline. It sits
// beside the datapath, watches register indices and control bits from the
// ID/EX/MEM/WB stages, and drives the pipeline-register stall/flush enables
// and the EX-operand forwarding mux selects.
//
// Features:
//   - NUM_FWD forwarding sources, youngest (index 0) has priority
//   - load-use bubble of LU_STALLS cycles (1 or 2)
//   - multi-cycle EX unit holding EX for MC_LAT-1 cycles
//   - saturating, synchronously clearable performance counters
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rs_id, rt_id               ID source registers
//   use_rs_id, use_rt_id       ID instruction really reads rs / rt
//   rs_ex, rt_ex, dest_ex      EX source / destination registers
//   memread_ex                 EX instruction is a load
//   mc_start_ex                multi-cycle op in its first EX cycle
//   dest_fwd, regwrite_fwd     per-source destination / write-enable
//   mispredict_ex, jump_id     control-flow redirects
//   clr_counters               synchronous clear of all counters
//   fwd_sel_a, fwd_sel_b       0 = regfile, k = forwarding source k-1
//   stall_if/id/ex             hold PC / IF-ID / ID-EX and EX
//   flush_if_id, flush_id_ex   bubble insertion
//   ctrl_state                 00 RUN, 01 LU, 10 MC
//   stall_cnt, lu_cnt, mispredict_cnt, fwd_cnt   performance counters
//
// Stalls, flushes and selects are combinational from the inputs and the
// registered state so the datapath sees them in the same cycle.
// -----------------------------------------------------------------------------
module hazard_ctrl_param #(
    parameter int REG_W     = 5,
    parameter int NUM_FWD   = 2,
    parameter int LU_STALLS = 1,
    parameter int MC_LAT    = 4,
    parameter int CNT_W     = 32,
    localparam int FSW      = $clog2(NUM_FWD + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [REG_W-1:0]           rs_id,
    input  logic [REG_W-1:0]           rt_id,
    input  logic                       use_rs_id,
    input  logic                       use_rt_id,
    input  logic [REG_W-1:0]           rs_ex,
    input  logic [REG_W-1:0]           rt_ex,
    input  logic [REG_W-1:0]           dest_ex,
    input  logic                       memread_ex,
    input  logic                       mc_start_ex,
    input  logic [NUM_FWD*REG_W-1:0]   dest_fwd,
    input  logic [NUM_FWD-1:0]         regwrite_fwd,
    input  logic                       mispredict_ex,
    input  logic                       jump_id,
    input  logic                       clr_counters,
    output logic [FSW-1:0]             fwd_sel_a,
    output logic [FSW-1:0]             fwd_sel_b,
    output logic                       stall_if,
    output logic                       stall_id,
    output logic                       stall_ex,
    output logic                       flush_if_id,
    output logic                       flush_id_ex,
    output logic [1:0]                 ctrl_state,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           lu_cnt,
    output logic [CNT_W-1:0]           mispredict_cnt,
    output logic [CNT_W-1:0]           fwd_cnt
);

    // mc_cnt counts remaining MC-state cycles minus one; the first stall
    // cycle is spent in RUN (the mc_start_ex cycle) so MC lasts MC_LAT-2.
    localparam int MCW     = $clog2(MC_LAT + 1);
    localparam int MC_INIT = (MC_LAT > 2) ? (MC_LAT - 3) : 0;

    typedef enum logic [1:0] {
        ST_RUN = 2'b00,
        ST_LU  = 2'b01,
        ST_MC  = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MCW-1:0]    r_mc_cnt;
    logic [MCW-1:0]    w_mc_cnt_nxt;

    logic              w_lu_hit;
    logic              w_lu_accept;
    logic              w_stall_if;
    logic              w_stall_id;
    logic              w_stall_ex;
    logic              w_flush_if_id;
    logic              w_flush_id_ex;
    logic [FSW-1:0]    w_sel_a;
    logic [FSW-1:0]    w_sel_b;
    logic              w_fwd_inc;

    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_lu_cnt;
    logic [CNT_W-1:0]  r_mispredict_cnt;
    logic [CNT_W-1:0]  r_fwd_cnt;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        logic [CNT_W-1:0] res;
        if (en && (v != {CNT_W{1'b1}})) begin
            res = v + CNT_W'(1);
        end else begin
            res = v;
        end
        return res;
    endfunction

    // Forward-source pick: scanning from the oldest source down lets the
    // youngest matching source overwrite any older match.
    function automatic logic [FSW-1:0] fwd_pick(input logic [REG_W-1:0]         src,
                                                input logic [NUM_FWD*REG_W-1:0] dst,
                                                input logic [NUM_FWD-1:0]       wen);
        logic [FSW-1:0] sel;
        sel = '0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            sel = (wen[k] && (dst[k*REG_W +: REG_W] != '0) &&
                   (dst[k*REG_W +: REG_W] == src)) ? FSW'(k + 1) : sel;
        end
        return sel;
    endfunction

    // Forwarding selects and load-use detection (state independent).
    always_comb begin
        w_sel_a  = fwd_pick(rs_ex, dest_fwd, regwrite_fwd);
        w_sel_b  = fwd_pick(rt_ex, dest_fwd, regwrite_fwd);
        w_lu_hit = memread_ex && (dest_ex != '0) &&
                   ((use_rs_id && (rs_id == dest_ex)) ||
                    (use_rt_id && (rt_id == dest_ex)));
    end

    // Next-state and stall/flush decode; a mispredict overrides every state.
    always_comb begin
        w_state_nxt   = r_state;
        w_mc_cnt_nxt  = r_mc_cnt;
        w_stall_if    = 1'b0;
        w_stall_id    = 1'b0;
        w_stall_ex    = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_lu_accept   = 1'b0;

        if (mispredict_ex) begin
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
            w_state_nxt   = ST_RUN;
            w_mc_cnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (mc_start_ex) begin
                        w_stall_if = 1'b1;
                        w_stall_id = 1'b1;
                        w_stall_ex = 1'b1;
                        if (MC_LAT > 2) begin
                            w_state_nxt  = ST_MC;
                            w_mc_cnt_nxt = MCW'(MC_INIT);
                        end else begin
                            w_state_nxt  = ST_RUN;
                        end
                    end else if (w_lu_hit) begin
                        w_stall_if    = 1'b1;
                        w_stall_id    = 1'b1;
                        w_flush_id_ex = 1'b1;
                        w_lu_accept   = 1'b1;
                        if (LU_STALLS == 2) begin
                            w_state_nxt = ST_LU;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else if (jump_id) begin
                        // Only reached when unstalled, so a jump seen while
                        // stalled is flushed on the first free cycle.
                        w_flush_if_id = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_LU: begin
                    w_stall_if    = 1'b1;
                    w_stall_id    = 1'b1;
                    w_flush_id_ex = 1'b1;
                    w_state_nxt   = ST_RUN;
                end
                ST_MC: begin
                    w_stall_if = 1'b1;
                    w_stall_id = 1'b1;
                    w_stall_ex = 1'b1;
                    if (r_mc_cnt == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_mc_cnt_nxt = r_mc_cnt - MCW'(1);
                    end
                end
                default: begin
                    w_state_nxt  = ST_RUN;
                    w_mc_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State register and multi-cycle down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_mc_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
        end
    end

    // Forwarding is only counted when the EX instruction actually advances.
    always_comb begin
        w_fwd_inc = ((w_sel_a != '0) || (w_sel_b != '0)) && !w_stall_ex;
    end

    // Performance counters; clear takes precedence over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt      <= '0;
            r_lu_cnt         <= '0;
            r_mispredict_cnt <= '0;
            r_fwd_cnt        <= '0;
        end else if (clr_counters) begin
            r_stall_cnt      <= '0;
            r_lu_cnt         <= '0;
            r_mispredict_cnt <= '0;
            r_fwd_cnt        <= '0;
        end else begin
            r_stall_cnt      <= sat_inc(r_stall_cnt, w_stall_id);
            r_lu_cnt         <= sat_inc(r_lu_cnt, w_lu_accept);
            r_mispredict_cnt <= sat_inc(r_mispredict_cnt, mispredict_ex);
            r_fwd_cnt        <= sat_inc(r_fwd_cnt, w_fwd_inc);
        end
    end

    assign fwd_sel_a      = w_sel_a;
    assign fwd_sel_b      = w_sel_b;
    assign stall_if       = w_stall_if;
    assign stall_id       = w_stall_id;
    assign stall_ex       = w_stall_ex;
    assign flush_if_id    = w_flush_if_id;
    assign flush_id_ex    = w_flush_id_ex;
    assign ctrl_state     = r_state;
    assign stall_cnt      = r_stall_cnt;
    assign lu_cnt         = r_lu_cnt;
    assign mispredict_cnt = r_mispredict_cnt;
    assign fwd_cnt        = r_fwd_cnt;

endmodule

// File: tb/tb_hazard_ctrl_param.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_ctrl_param (NUM_FWD=2, LU_STALLS=2, MC_LAT=4, CNT_W=4).
// Directed scenarios plus a randomized run compared against a behavioural
// model that tracks "mode + cycles left" and integer counters clipped at max.
// Inputs change #1 after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_param;

    localparam int REG_W     = 5;
    localparam int NUM_FWD   = 2;
    localparam int LU_STALLS = 2;
    localparam int MC_LAT    = 4;
    localparam int CNT_W     = 4;
    localparam int FSW       = 2;
    localparam int CMAX      = 15;

    logic                     clk;
    logic                     reset;
    logic [REG_W-1:0]         rs_id, rt_id, rs_ex, rt_ex, dest_ex;
    logic                     use_rs_id, use_rt_id, memread_ex, mc_start_ex;
    logic [NUM_FWD*REG_W-1:0] dest_fwd;
    logic [NUM_FWD-1:0]       regwrite_fwd;
    logic                     mispredict_ex, jump_id, clr_counters;
    logic [FSW-1:0]           fwd_sel_a, fwd_sel_b;
    logic                     stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex;
    logic [1:0]               ctrl_state;
    logic [CNT_W-1:0]         stall_cnt, lu_cnt, mispredict_cnt, fwd_cnt;
    logic [4:0]               ctl;

    int n_cmp;
    int n_bad;

    // model state
    int m_mode;   // 0 run, 1 load-use bubble, 2 multi-cycle
    int m_left;   // cycles left in the current non-run mode
    int m_stall, m_lu, m_mis, m_fwd;
    int e_sel_a, e_sel_b;
    bit e_si, e_sd, e_se, e_fif, e_fie, e_hit;

    hazard_ctrl_param #(
        .REG_W(REG_W), .NUM_FWD(NUM_FWD), .LU_STALLS(LU_STALLS),
        .MC_LAT(MC_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .rs_id(rs_id), .rt_id(rt_id), .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex), .dest_ex(dest_ex),
        .memread_ex(memread_ex), .mc_start_ex(mc_start_ex),
        .dest_fwd(dest_fwd), .regwrite_fwd(regwrite_fwd),
        .mispredict_ex(mispredict_ex), .jump_id(jump_id), .clr_counters(clr_counters),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .ctrl_state(ctrl_state),
        .stall_cnt(stall_cnt), .lu_cnt(lu_cnt),
        .mispredict_cnt(mispredict_cnt), .fwd_cnt(fwd_cnt)
    );

    assign ctl = {stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic int exp_sel(input logic [REG_W-1:0] src);
        int r;
        r = 0;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (r == 0 && regwrite_fwd[k] && dest_fwd[k*REG_W +: REG_W] != 5'd0 &&
                dest_fwd[k*REG_W +: REG_W] == src) r = k + 1;
        end
        return r;
    endfunction

    task automatic mdl_reset();
        m_mode = 0; m_left = 0;
        m_stall = 0; m_lu = 0; m_mis = 0; m_fwd = 0;
    endtask

    task automatic mdl_eval();
        e_hit = memread_ex && dest_ex != 5'd0 &&
                ((use_rs_id && rs_id == dest_ex) || (use_rt_id && rt_id == dest_ex));
        e_sel_a = exp_sel(rs_ex);
        e_sel_b = exp_sel(rt_ex);
        {e_si, e_sd, e_se, e_fif, e_fie} = 5'b00000;
        if (mispredict_ex) begin
            e_fif = 1; e_fie = 1;
        end else if (m_mode == 1) begin
            e_si = 1; e_sd = 1; e_fie = 1;
        end else if (m_mode == 2) begin
            e_si = 1; e_sd = 1; e_se = 1;
        end else if (mc_start_ex) begin
            e_si = 1; e_sd = 1; e_se = 1;
        end else if (e_hit) begin
            e_si = 1; e_sd = 1; e_fie = 1;
        end else if (jump_id) begin
            e_fif = 1;
        end
    endtask

    // advance the model by one clock using the inputs currently applied
    task automatic mdl_step();
        bit lu_acc;
        mdl_eval();
        lu_acc = (m_mode == 0) && !mispredict_ex && !mc_start_ex && e_hit;
        if (clr_counters) begin
            m_stall = 0; m_lu = 0; m_mis = 0; m_fwd = 0;
        end else begin
            m_stall = sat(m_stall + int'(e_sd));
            m_lu    = sat(m_lu + int'(lu_acc));
            m_mis   = sat(m_mis + int'(mispredict_ex));
            m_fwd   = sat(m_fwd + int'((e_sel_a != 0 || e_sel_b != 0) && !e_se));
        end
        if (mispredict_ex) begin
            m_mode = 0;
        end else if (m_mode != 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = 0;
        end else if (mc_start_ex) begin
            if (MC_LAT > 2) begin m_mode = 2; m_left = MC_LAT - 2; end
        end else if (e_hit) begin
            if (LU_STALLS == 2) begin m_mode = 1; m_left = 1; end
        end
    endtask

    // called at negedge: step the model, then move to posedge+1
    task automatic advance();
        mdl_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rs_id = '0; rt_id = '0; use_rs_id = 0; use_rt_id = 0;
        rs_ex = '0; rt_ex = '0; dest_ex = '0; memread_ex = 0; mc_start_ex = 0;
        dest_fwd = '0; regwrite_fwd = '0; mispredict_ex = 0; jump_id = 0;
        clr_counters = 0;
    endtask

    task automatic clear_cycle();
        set_idle();
        clr_counters = 1;
        @(negedge clk);
        advance();
        clr_counters = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({ctl, fwd_sel_a, fwd_sel_b, ctrl_state} !== 11'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %b expected 0", {ctl, fwd_sel_a, fwd_sel_b, ctrl_state});
        end
        n_cmp++;
        if ({stall_cnt, lu_cnt, mispredict_cnt, fwd_cnt} !== 16'd0) begin
            n_bad++; $display("FAIL reset_counters: got %h expected 0", {stall_cnt, lu_cnt, mispredict_cnt, fwd_cnt});
        end
        reset = 0;
        advance();
    endtask

    task automatic test_forwarding();
        set_idle();
        rs_ex = 5'd5; rt_ex = 5'd5; dest_fwd = {5'd5, 5'd5}; regwrite_fwd = 2'b11;
        @(negedge clk);
        n_cmp++;
        if (fwd_sel_a !== 2'd1 || fwd_sel_b !== 2'd1) begin
            n_bad++; $display("FAIL fwd_youngest: got %0d/%0d expected 1/1", fwd_sel_a, fwd_sel_b);
        end
        advance();
        regwrite_fwd = 2'b10;
        @(negedge clk);
        n_cmp++;
        if (fwd_sel_a !== 2'd2) begin
            n_bad++; $display("FAIL fwd_older: got %0d expected 2", fwd_sel_a);
        end
        advance();
        dest_fwd = '0; rs_ex = 5'd0; regwrite_fwd = 2'b11;
        @(negedge clk);
        n_cmp++;
        if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin
            n_bad++; $display("FAIL fwd_r0: got %0d/%0d expected 0/0", fwd_sel_a, fwd_sel_b);
        end
        advance();
        rs_ex = 5'd3; rt_ex = 5'd7; dest_fwd = {5'd3, 5'd7};
        @(negedge clk);
        n_cmp++;
        if (fwd_sel_a !== 2'd2 || fwd_sel_b !== 2'd1) begin
            n_bad++; $display("FAIL fwd_split: got %0d/%0d expected 2/1", fwd_sel_a, fwd_sel_b);
        end
        advance();
        set_idle();
    endtask

    task automatic test_load_use();
        clear_cycle();
        memread_ex = 1; dest_ex = 5'd8; rs_id = 5'd8; use_rs_id = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl !== 5'b11001 || ctrl_state !== 2'(c)) begin
                n_bad++; $display("FAIL lu_bubble%0d: got ctl=%b st=%b expected 11001 st=%0d", c, ctl, ctrl_state, c);
            end
            advance();
        end
        use_rs_id = 0;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 5'b00000 || ctrl_state !== 2'b00) begin
            n_bad++; $display("FAIL lu_unused_rs: got ctl=%b st=%b expected 0", ctl, ctrl_state);
        end
        n_cmp++;
        if (lu_cnt !== 4'd1 || stall_cnt !== 4'd2) begin
            n_bad++; $display("FAIL lu_counts: got lu=%0d stall=%0d expected 1/2", lu_cnt, stall_cnt);
        end
        advance();
        use_rt_id = 1; rt_id = 5'd8;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 5'b11001) begin
            n_bad++; $display("FAIL lu_rt: got %b expected 11001", ctl);
        end
        advance();
        jump_id = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 5'b11001 || ctrl_state !== 2'b01) begin
            n_bad++; $display("FAIL jump_stalled: got ctl=%b st=%b expected 11001 st=1", ctl, ctrl_state);
        end
        advance();
        set_idle(); jump_id = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 5'b00010) begin
            n_bad++; $display("FAIL jump_free: got %b expected 00010", ctl);
        end
        advance();
        set_idle(); memread_ex = 1; use_rs_id = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 5'b00000) begin
            n_bad++; $display("FAIL lu_r0: got %b expected 0", ctl);
        end
        advance();
        set_idle();
    endtask

    task automatic test_multicycle();
        set_idle(); mc_start_ex = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl !== ((c < 3) ? 5'b11100 : 5'b00000) ||
                ctrl_state !== ((c == 1 || c == 2) ? 2'b10 : 2'b00)) begin
                n_bad++; $display("FAIL mc_cycle%0d: got ctl=%b st=%b", c, ctl, ctrl_state);
            end
            advance();
            mc_start_ex = 0;
        end
        mc_start_ex = 1;
        @(negedge clk); advance();
        mc_start_ex = 0;
        @(negedge clk); advance();
        mispredict_ex = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 5'b00011 || ctrl_state !== 2'b10) begin
            n_bad++; $display("FAIL mc_mispredict: got ctl=%b st=%b expected 00011 st=10", ctl, ctrl_state);
        end
        advance();
        mispredict_ex = 0;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 5'b00000 || ctrl_state !== 2'b00) begin
            n_bad++; $display("FAIL mc_after_mispredict: got ctl=%b st=%b expected 0", ctl, ctrl_state);
        end
        advance();
    endtask

    task automatic test_priority();
        clear_cycle();
        mispredict_ex = 1; mc_start_ex = 1; jump_id = 1;
        memread_ex = 1; dest_ex = 5'd8; rs_id = 5'd8; use_rs_id = 1;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 5'b00011) begin
            n_bad++; $display("FAIL prio_outputs: got %b expected 00011", ctl);
        end
        advance();
        set_idle();
        @(negedge clk);
        n_cmp++;
        if (ctrl_state !== 2'b00 || mispredict_cnt !== 4'd1 || lu_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
            n_bad++; $display("FAIL prio_after: got st=%b mis=%0d lu=%0d stall=%0d expected 0/1/0/0",
                              ctrl_state, mispredict_cnt, lu_cnt, stall_cnt);
        end
        advance();
    endtask

    task automatic test_saturation();
        clear_cycle();
        memread_ex = 1; dest_ex = 5'd9; rt_id = 5'd9; use_rt_id = 1;
        repeat (20) begin
            @(negedge clk);
            advance();
        end
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== 4'd15 || lu_cnt !== 4'd10) begin
            n_bad++; $display("FAIL sat_stall: got stall=%0d lu=%0d expected 15/10", stall_cnt, lu_cnt);
        end
        clr_counters = 1;
        advance();
        clr_counters = 0;
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== 4'd0 || lu_cnt !== 4'd0) begin
            n_bad++; $display("FAIL sat_clear: got stall=%0d lu=%0d expected 0/0", stall_cnt, lu_cnt);
        end
        advance();
        set_idle();
        repeat (2) begin
            @(negedge clk);
            advance();
        end
    endtask

    task automatic test_reset_mid_mc();
        set_idle(); mc_start_ex = 1;
        @(negedge clk); advance();
        mc_start_ex = 0;
        #1 reset = 1;
        #1;
        n_cmp++;
        if (ctrl_state !== 2'b00 || {stall_cnt, lu_cnt, mispredict_cnt, fwd_cnt} !== 16'd0) begin
            n_bad++; $display("FAIL reset_async: got st=%b cnt=%h expected 0", ctrl_state,
                              {stall_cnt, lu_cnt, mispredict_cnt, fwd_cnt});
        end
        mdl_reset();
        #1 reset = 0;
        @(negedge clk);
        n_cmp++;
        if ({ctl, fwd_sel_a, fwd_sel_b, ctrl_state} !== 11'd0) begin
            n_bad++; $display("FAIL reset_release: got %b expected 0", {ctl, fwd_sel_a, fwd_sel_b, ctrl_state});
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rs_id = 5'($urandom_range(0, 3));  rt_id = 5'($urandom_range(0, 3));
            rs_ex = 5'($urandom_range(0, 3));  rt_ex = 5'($urandom_range(0, 3));
            dest_ex = 5'($urandom_range(0, 3));
            dest_fwd = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            regwrite_fwd = 2'($urandom_range(0, 3));
            use_rs_id = 1'($urandom_range(0, 1)); use_rt_id = 1'($urandom_range(0, 1));
            memread_ex = ($urandom_range(0, 2) == 0);
            mc_start_ex = ($urandom_range(0, 9) == 0);
            mispredict_ex = ($urandom_range(0, 15) == 0);
            jump_id = ($urandom_range(0, 3) == 0);
            clr_counters = ($urandom_range(0, 40) == 0);
            @(negedge clk);
            mdl_eval();
            n_cmp++;
            if (fwd_sel_a !== FSW'(e_sel_a) || fwd_sel_b !== FSW'(e_sel_b)) begin
                n_bad++; $display("FAIL rnd_fwd@%0d: got %0d/%0d expected %0d/%0d", i, fwd_sel_a, fwd_sel_b, e_sel_a, e_sel_b);
            end
            n_cmp++;
            if (ctl !== {e_si, e_sd, e_se, e_fif, e_fie}) begin
                n_bad++; $display("FAIL rnd_ctl@%0d: got %b expected %b", i, ctl, {e_si, e_sd, e_se, e_fif, e_fie});
            end
            n_cmp++;
            if (ctrl_state !== 2'(m_mode)) begin
                n_bad++; $display("FAIL rnd_state@%0d: got %0d expected %0d", i, ctrl_state, m_mode);
            end
            n_cmp++;
            if (stall_cnt !== CNT_W'(m_stall) || lu_cnt !== CNT_W'(m_lu) ||
                mispredict_cnt !== CNT_W'(m_mis) || fwd_cnt !== CNT_W'(m_fwd)) begin
                n_bad++; $display("FAIL rnd_cnt@%0d: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", i,
                                  stall_cnt, lu_cnt, mispredict_cnt, fwd_cnt, m_stall, m_lu, m_mis, m_fwd);
            end
            advance();
        end
        set_idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        set_idle();
        reset = 1;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_multicycle();
        test_priority();
        test_saturation();
        test_reset_mid_mc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
